// File: rtl/cam_pkg.sv
// Shared op-codes, sequencer states and default geometry for the CAM command sequencer.
package cam_pkg;

   localparam int CAM_WORDS = 64;
   localparam int CAM_WIDTH = 32;
   localparam int CAM_IDXW  = 6;
   localparam int CAM_LATW  = 3;

   typedef enum logic [2:0] {
      CAM_NOP          = 3'd0,
      CAM_SEARCH       = 3'd1,
      CAM_WRITE_TAGGED = 3'd2,
      CAM_READ_ALL     = 3'd3,
      CAM_COUNT        = 3'd4,
      CAM_SET_ALL      = 3'd5
   } cam_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_SETTLE,
      ST_WRITE,
      ST_SEL,
      ST_RD,
      ST_CLR,
      ST_RSP
   } cam_state_e;

endpackage

// File: rtl/cam_seq_ctrl_if.sv
// Host-side command and response channels of the CAM sequencer (valid/ready both ways).
interface cam_seq_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int IDXW  = 6
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_comparand;
   logic [WIDTH-1:0] cmd_mask;
   logic [WIDTH-1:0] cmd_data;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic [IDXW-1:0]  rsp_index;
   logic             rsp_last;

   modport master (
      output cmd_valid, cmd_op, cmd_comparand, cmd_mask, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_index, rsp_last
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_comparand, cmd_mask, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_index, rsp_last
   );
endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-set-index priority encoder over the responder vector; purely combinational.
module cam_prio_enc #(
   parameter int WORDS = 64,
   parameter int IDXW  = 6
) (
   input  logic [WORDS-1:0] tags,
   output logic [IDXW-1:0]  first,
   output logic             any
);

   // Scanning downward lets the lowest set bit win without a break.
   always_comb begin
      first = '0;
      for (int i = WORDS - 1; i >= 0; i--) begin
         if (tags[i]) begin
            first = IDXW'(i);
         end
      end
   end

   assign any = |tags;

endmodule

// File: rtl/cam_seq_ctrl.sv
// CAM command sequencer: host commands become registered one-cycle array strobes and counted/read responses.
// A response is held in RSP until rsp_ready; no strobe fires while a response is pending.
module cam_seq_ctrl
   import cam_pkg::*;
#(
   parameter int WORDS      = CAM_WORDS,
   parameter int WIDTH      = CAM_WIDTH,
   parameter int SEARCH_LAT = 2,
   parameter int IDXW       = CAM_IDXW
) (
   input  logic             clk,
   input  logic             rst_n,
   cam_seq_ctrl_if.slave    bus,
   output logic [WIDTH-1:0] comparand,
   output logic [WIDTH-1:0] mask,
   output logic             perform_search,
   output logic             set,
   output logic             select_first,
   output logic             tag_clr,
   output logic [IDXW-1:0]  tag_clr_idx,
   output logic             write_en,
   output logic [WIDTH-1:0] write_data,
   input  logic [WORDS-1:0] tags,
   input  logic [WIDTH-1:0] read_data,
   output logic             err
);

   cam_state_e          state, state_nxt;
   logic [2:0]          op, op_nxt;
   logic [CAM_LATW-1:0] lat_cnt, lat_nxt;
   logic                walk, walk_nxt;
   logic                err_nxt;
   logic                load_cmd;
   logic                set_nxt, ps_nxt, sel_nxt, clr_nxt, wr_nxt;
   logic                cmd_ready_q, rsp_valid_q, rsp_last_q, rlast_nxt;
   logic [WIDTH-1:0]    rsp_data_q, rdat_nxt;
   logic [IDXW-1:0]     rsp_index_q, ridx_nxt;
   logic [IDXW-1:0]     first;
   logic                any;

   function automatic logic [IDXW:0] popcount(input logic [WORDS-1:0] v);
      logic [IDXW:0] c;
      c = '0;
      for (int i = 0; i < WORDS; i++) begin
         c = c + (IDXW+1)'(v[i]);
      end
      return c;
   endfunction

   function automatic logic [WORDS-1:0] onehot(input logic [IDXW-1:0] i);
      logic [WORDS-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   cam_prio_enc #(.WORDS(WORDS), .IDXW(IDXW)) u_prio (
      .tags  (tags),
      .first (first),
      .any   (any)
   );

   always_comb begin
      state_nxt = state;
      op_nxt    = op;
      lat_nxt   = lat_cnt;
      walk_nxt  = walk;
      err_nxt   = err;
      load_cmd  = 1'b0;
      set_nxt   = 1'b0;
      ps_nxt    = 1'b0;
      sel_nxt   = 1'b0;
      clr_nxt   = 1'b0;
      wr_nxt    = 1'b0;
      rdat_nxt  = rsp_data_q;
      ridx_nxt  = rsp_index_q;
      rlast_nxt = rsp_last_q;
      case (state)
         ST_IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               load_cmd  = 1'b1;
               op_nxt    = bus.cmd_op;
               rdat_nxt  = '0;
               ridx_nxt  = '0;
               rlast_nxt = 1'b1;
               case (bus.cmd_op)
                  CAM_NOP: state_nxt = ST_RSP;
                  CAM_SEARCH, CAM_SET_ALL: begin
                     state_nxt = ST_SEARCH;
                     set_nxt   = 1'b1;
                  end
                  CAM_WRITE_TAGGED: begin
                     state_nxt = ST_WRITE;
                     wr_nxt    = 1'b1;
                  end
                  CAM_READ_ALL: begin
                     walk_nxt  = any;
                     state_nxt = any ? ST_SEL : ST_RSP;
                     sel_nxt   = any;
                  end
                  // COUNT reuses SETTLE with the wait already expired: sample next cycle.
                  CAM_COUNT: begin
                     state_nxt = ST_SETTLE;
                     lat_nxt   = CAM_LATW'(SEARCH_LAT);
                  end
                  default: begin
                     state_nxt = ST_RSP;
                     err_nxt   = 1'b1;
                  end
               endcase
            end
         end
         ST_SEARCH: begin
            if (op == CAM_SEARCH) begin
               state_nxt = ST_SETTLE;
               ps_nxt    = 1'b1;
               lat_nxt   = '0;
            end else begin
               state_nxt = ST_RSP;
            end
         end
         ST_SETTLE: begin
            if (lat_cnt == CAM_LATW'(SEARCH_LAT)) begin
               rdat_nxt  = WIDTH'(popcount(tags));
               state_nxt = ST_RSP;
            end else begin
               lat_nxt = lat_cnt + 3'd1;
            end
         end
         ST_WRITE: state_nxt = ST_RSP;
         ST_SEL:   state_nxt = ST_RD;
         ST_RD: begin
            rdat_nxt  = read_data;
            ridx_nxt  = first;
            rlast_nxt = ~|(tags & ~onehot(first));
            state_nxt = ST_RSP;
         end
         ST_RSP: begin
            if (bus.rsp_ready) begin
               state_nxt = walk ? ST_CLR : ST_IDLE;
               clr_nxt   = walk;
            end
         end
         ST_CLR: begin
            if (|(tags & ~onehot(rsp_index_q))) begin
               state_nxt = ST_SEL;
               sel_nxt   = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
               walk_nxt  = 1'b0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         op             <= '0;
         lat_cnt        <= '0;
         walk           <= 1'b0;
         err            <= 1'b0;
         cmd_ready_q    <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_data_q     <= '0;
         rsp_index_q    <= '0;
         rsp_last_q     <= 1'b0;
         set            <= 1'b0;
         perform_search <= 1'b0;
         select_first   <= 1'b0;
         tag_clr        <= 1'b0;
         tag_clr_idx    <= '0;
         write_en       <= 1'b0;
         comparand      <= '0;
         mask           <= '0;
         write_data     <= '0;
      end else begin
         state          <= state_nxt;
         op             <= op_nxt;
         lat_cnt        <= lat_nxt;
         walk           <= walk_nxt;
         err            <= err_nxt;
         cmd_ready_q    <= (state_nxt == ST_IDLE);
         rsp_valid_q    <= (state_nxt == ST_RSP);
         rsp_data_q     <= rdat_nxt;
         rsp_index_q    <= ridx_nxt;
         rsp_last_q     <= rlast_nxt;
         set            <= set_nxt;
         perform_search <= ps_nxt;
         select_first   <= sel_nxt;
         tag_clr        <= clr_nxt;
         tag_clr_idx    <= clr_nxt ? rsp_index_q : '0;
         write_en       <= wr_nxt;
         if (load_cmd) begin
            comparand  <= bus.cmd_comparand;
            mask       <= bus.cmd_mask;
            write_data <= bus.cmd_data;
         end
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_index = rsp_index_q;
   assign bus.rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_cam_seq_ctrl.sv
// Directed bench for cam_seq_ctrl: array stub, response/strobe scoreboard, literal spot checks.
module tb_cam_seq_ctrl;
   import cam_pkg::*;

   localparam int WORDS = 64;
   localparam int WIDTH = 32;
   localparam int IDXW  = 6;
   localparam int LAT   = 2;

   typedef struct { int kind; int idx; int off; } stb_t;
   typedef struct { logic [31:0] data; int idx; bit last; } rsp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cam_seq_ctrl_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

   logic [WIDTH-1:0] comparand, mask, write_data;
   logic             perform_search, set, select_first, tag_clr, write_en, err;
   logic [IDXW-1:0]  tag_clr_idx;
   logic [WORDS-1:0] tags = '0;
   logic [WORDS-1:0] srch = '0;
   logic [WIDTH-1:0] read_data = '0;
   int               cd = 0;

   cam_seq_ctrl #(.WORDS(WORDS), .WIDTH(WIDTH), .SEARCH_LAT(LAT), .IDXW(IDXW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .comparand(comparand), .mask(mask), .perform_search(perform_search), .set(set),
      .select_first(select_first), .tag_clr(tag_clr), .tag_clr_idx(tag_clr_idx),
      .write_en(write_en), .write_data(write_data), .tags(tags), .read_data(read_data), .err(err)
   );

   function automatic logic [31:0] lowest_word(input logic [WORDS-1:0] t);
      for (int i = 0; i < WORDS; i++) if (t[i]) return 32'h100 + 32'(i);
      return 32'h0;
   endfunction

   // Array stub: word i holds 0x100+i; search result lands LAT cycles after the strobe.
   always @(posedge clk) begin
      if (perform_search && LAT == 1) tags <= srch;
      if (cd == 1) tags <= srch;
      if (perform_search) cd <= LAT - 1;
      else if (cd > 0) cd <= cd - 1;
      if (set) tags <= '1;
      if (tag_clr) tags[tag_clr_idx] <= 1'b0;
      if (select_first) read_data <= lowest_word(tags);
   end

   stb_t exp_stb[$];
   rsp_t exp_rsp[$];
   rsp_t log_rsp[$];
   int   checks = 0, errors = 0;
   int   cyc = 0, acc_cyc = 0, rsp_cnt = 0, hold_seen = 0;
   int   stall_idx = -1, stall_left = 0;
   logic [31:0] exp_cmp = '0, exp_msk = '0, exp_wdat = '0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic push_rsp(input logic [31:0] d, input int i, input bit l);
      rsp_t r;
      r.data = d; r.idx = i; r.last = l;
      exp_rsp.push_back(r);
   endtask

   task automatic push_stb(input int k, input int i, input int o);
      stb_t s;
      s.kind = k; s.idx = i; s.off = o;
      exp_stb.push_back(s);
   endtask

   // Expected behaviour from the command rules; kinds 0 set,1 search,2 select,3 clear,4 write.
   task automatic model(input logic [2:0] op, input logic [31:0] c, input logic [31:0] m, input logic [31:0] d);
      int hi;
      exp_cmp = c; exp_msk = m; exp_wdat = d;
      case (op)
         3'd0: push_rsp(0, 0, 1);
         3'd1: begin push_stb(0, 0, 1); push_stb(1, 0, 2); push_rsp($countones(srch), 0, 1); end
         3'd2: begin push_stb(4, 0, 1); push_rsp(0, 0, 1); end
         3'd3: begin
            if (tags == '0) push_rsp(0, 0, 1);
            else begin
               hi = 0;
               for (int i = 0; i < WORDS; i++) if (tags[i]) hi = i;
               for (int i = 0; i < WORDS; i++) begin
                  if (tags[i]) begin
                     push_stb(2, 0, -1);
                     push_rsp(32'h100 + 32'(i), i, i == hi);
                     push_stb(3, i, -1);
                  end
               end
            end
         end
         3'd4: push_rsp($countones(tags), 0, 1);
         3'd5: begin push_stb(0, 0, 1); push_rsp(0, 0, 1); end
         default: push_rsp(0, 0, 1);
      endcase
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] c, input logic [31:0] m, input logic [31:0] d);
      int n;
      model(op, c, m, d);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_op = op;
      bus.cmd_comparand = c; bus.cmd_mask = m; bus.cmd_data = d;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (bus.cmd_ready) break;
         n++;
         if (n > 100) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout got cmd_ready 0 expected 1");
            break;
         end
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (exp_rsp.size() != 0 || exp_stb.size() != 0 || !bus.cmd_ready) begin
         @(negedge clk);
         n++;
         if (n > 300) begin
            checks++; errors++;
            $display("FAIL %s_timeout got pending rsp %0d stb %0d expected 0", name, exp_rsp.size(), exp_stb.size());
            exp_rsp.delete(); exp_stb.delete();
            break;
         end
      end
   endtask

   function automatic logic [63:0] outs_or();
      return 64'(|{comparand, mask, perform_search, set, select_first, tag_clr, tag_clr_idx, write_en,
                   write_data, err, bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_index, bus.rsp_last});
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      bus.rsp_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (bus.rsp_valid && rsp_cnt == stall_idx && stall_left > 0) begin
            bus.rsp_ready = 1'b0;
            stall_left--;
         end else begin
            bus.rsp_ready = 1'b1;
         end
      end
   end

   // Compare process: every strobe and every response handshake against the model queues.
   initial begin
      logic [4:0] sv;
      bit   prev_hold;
      rsp_t prev, r;
      stb_t e;
      bit   ok;
      prev_hold = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_hold = 0;
         end else begin
            if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
            sv = {write_en, tag_clr, select_first, perform_search, set};
            if (sv != 5'b0) begin
               checks++;
               if ($countones(sv) != 1 || exp_stb.size() == 0) begin
                  errors++;
                  $display("FAIL strobe_unexpected got %b pending %0d expected one queued strobe", sv, exp_stb.size());
               end else begin
                  e = exp_stb.pop_front();
                  ok = sv[e.kind] && (e.off < 0 || cyc == acc_cyc + e.off)
                       && (e.kind != 3 || int'(tag_clr_idx) == e.idx)
                       && (e.kind != 4 || (write_data == exp_wdat && mask == exp_msk))
                       && (e.kind != 1 || (comparand == exp_cmp && mask == exp_msk));
                  if (!ok) begin
                     errors++;
                     $display("FAIL strobe got %b cyc +%0d idx %0d expected kind %0d off %0d idx %0d",
                              sv, cyc - acc_cyc, tag_clr_idx, e.kind, e.off, e.idx);
                  end
               end
            end
            if (bus.rsp_valid) begin
               checks++;
               if (sv != 5'b0) begin
                  errors++;
                  $display("FAIL strobe_during_rsp got %b expected 0", sv);
               end
            end
            if (prev_hold) begin
               checks++; hold_seen++;
               if (!bus.rsp_valid || bus.rsp_data != prev.data || int'(bus.rsp_index) != prev.idx || bus.rsp_last != prev.last) begin
                  errors++;
                  $display("FAIL rsp_hold got v%0d %0h/%0d/%0d expected v1 %0h/%0d/%0d", bus.rsp_valid,
                           bus.rsp_data, bus.rsp_index, bus.rsp_last, prev.data, prev.idx, prev.last);
               end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
               checks++;
               r.data = bus.rsp_data; r.idx = int'(bus.rsp_index); r.last = bus.rsp_last;
               log_rsp.push_back(r);
               rsp_cnt++;
               if (exp_rsp.size() == 0) begin
                  errors++;
                  $display("FAIL rsp_unexpected got %0h/%0d/%0d expected none", r.data, r.idx, r.last);
               end else begin
                  prev = exp_rsp.pop_front();
                  if (r.data != prev.data || r.idx != prev.idx || r.last != prev.last) begin
                     errors++;
                     $display("FAIL rsp got %0h/%0d/%0d expected %0h/%0d/%0d", r.data, r.idx, r.last,
                              prev.data, prev.idx, prev.last);
                  end
               end
            end
            prev_hold = bus.rsp_valid && !bus.rsp_ready;
            prev.data = bus.rsp_data; prev.idx = int'(bus.rsp_index); prev.last = bus.rsp_last;
         end
      end
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog got no finish expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      logic [31:0] ed [3];
      int          ei [3];
      int          n, h0;
      rsp_t        lr;
      ed[0] = 32'h103; ed[1] = 32'h111; ed[2] = 32'h128;
      ei[0] = 3; ei[1] = 17; ei[2] = 40;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0;
      bus.cmd_comparand = '0; bus.cmd_mask = '0; bus.cmd_data = '0;

      #12;
      chk("reset_outputs", outs_or(), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // reset asserted during the perform_search cycle
      srch = '0; srch[3] = 1'b1; srch[17] = 1'b1; srch[40] = 1'b1;
      send(3'd1, 32'hAB, 32'hFF, 32'h0);
      n = 0;
      while (!perform_search && n < 20) begin @(negedge clk); n++; end
      chk("mid_search_strobe_seen", 64'(perform_search), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk("mid_search_reset_outputs", outs_or(), 64'd0);
      exp_rsp.delete(); exp_stb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      log_rsp.delete();
      send(3'd1, 32'h0000_00AB, 32'h0000_00FF, 32'h0);
      wait_done("search");
      chk("search_rsp_count", 64'(log_rsp.size()), 64'd1);
      if (log_rsp.size() > 0) begin
         lr = log_rsp[0];
         chk("search_popcount", 64'(lr.data), 64'd3);
         chk("search_last", 64'(lr.last), 64'd1);
      end
      chk("search_comparand", 64'(comparand), 64'hAB);
      chk("search_mask", 64'(mask), 64'hFF);

      log_rsp.delete();
      send(3'd3, 32'h0, 32'h0, 32'h0);
      wait_done("read_all");
      chk("read_all_rsp_count", 64'(log_rsp.size()), 64'd3);
      for (int k = 0; k < 3; k++) begin
         if (k < log_rsp.size()) begin
            chk("read_all_data", 64'(log_rsp[k].data), 64'(ed[k]));
            chk("read_all_index", 64'(log_rsp[k].idx), 64'(ei[k]));
            chk("read_all_last", 64'(log_rsp[k].last), 64'(k == 2));
         end
      end
      chk("read_all_tags_consumed", 64'(tags), 64'd0);

      srch = '0; srch[5] = 1'b1; srch[9] = 1'b1; srch[60] = 1'b1;
      send(3'd1, 32'h1, 32'h1, 32'h0);
      wait_done("search2");
      h0 = hold_seen;
      stall_idx = rsp_cnt + 1;
      stall_left = 5;
      log_rsp.delete();
      send(3'd3, 32'h0, 32'h0, 32'h0);
      wait_done("read_all_stall");
      chk("stall_hold_cycles", 64'(hold_seen - h0), 64'd5);
      if (log_rsp.size() > 1) chk("stall_second_data", 64'(log_rsp[1].data), 64'h109);
      chk("stall_tags_consumed", 64'(tags), 64'd0);

      log_rsp.delete();
      send(3'd3, 32'h0, 32'h0, 32'h0);
      wait_done("read_all_empty");
      chk("empty_rsp_count", 64'(log_rsp.size()), 64'd1);
      if (log_rsp.size() > 0) begin
         chk("empty_data", 64'(log_rsp[0].data), 64'd0);
         chk("empty_last", 64'(log_rsp[0].last), 64'd1);
      end

      srch = 64'h5;
      send(3'd1, 32'h0, 32'h0, 32'h0);
      wait_done("search3");
      log_rsp.delete();
      send(3'd2, 32'h0, 32'hFFFF_0000, 32'hDEAD_BEEF);
      wait_done("write");
      chk("write_data_reg", 64'(write_data), 64'hDEAD_BEEF);
      chk("write_mask_reg", 64'(mask), 64'hFFFF_0000);
      if (log_rsp.size() > 0) chk("write_rsp_data", 64'(log_rsp[0].data), 64'd0);
      chk("write_tags_unchanged", 64'(tags), 64'h5);

      chk("err_before_illegal", 64'(err), 64'd0);
      log_rsp.delete();
      send(3'd7, 32'h0, 32'h0, 32'h0);
      wait_done("illegal");
      chk("err_set", 64'(err), 64'd1);
      if (log_rsp.size() > 0) chk("illegal_last", 64'(log_rsp[0].last), 64'd1);
      send(3'd0, 32'h0, 32'h0, 32'h0);
      wait_done("nop");
      chk("err_sticky", 64'(err), 64'd1);

      send(3'd5, 32'h0, 32'h0, 32'h0);
      wait_done("set_all");
      log_rsp.delete();
      send(3'd4, 32'h0, 32'h0, 32'h0);
      wait_done("count");
      if (log_rsp.size() > 0) chk("count_all_ones", 64'(log_rsp[0].data), 64'd64);

      #3 rst_n = 1'b0;
      #1 chk("final_reset_outputs", outs_or(), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
